// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the multi-channel button debouncer.
//   btn_state_e : per-channel FSM encoding
//   tick_div()  : clk cycles per millisecond tick
//   cnt_width() : counter width able to hold 0..max_val (at least 1 bit)
package btn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDbPress,
    StHeld,
    StDbRelease
  } btn_state_e;

  function automatic int unsigned tick_div(input int unsigned freq);
    return freq / 1000;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, debounce/press-tracking FSM and counters.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   tick_i         : 1-cycle millisecond strobe from the shared timebase
//   pin_i          : raw asynchronous button pin
//   repeat_en_i    : auto-repeat enable, sampled on the cycle a repeat falls due
//   level_o        : debounced level, 1 = pressed
//   press_o, release_o, long_o, repeat_o : registered 1-cycle event pulses
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DebounceMs  = 20,
  parameter int unsigned LongMs      = 1000,
  parameter int unsigned RepeatMs    = 200,
  parameter bit          ActiveLevel = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic pin_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int unsigned DbW   = cnt_width(DebounceMs);
  localparam int unsigned HoldW = cnt_width(LongMs);
  localparam int unsigned RepW  = cnt_width(RepeatMs);

  localparam logic [DbW-1:0]   DbMax     = DbW'(DebounceMs);
  localparam logic [HoldW-1:0] HoldMax   = HoldW'(LongMs);
  localparam logic [RepW-1:0]  RepMax    = RepW'(RepeatMs);
  localparam bit               RepEnable = (RepeatMs != 0);

  logic [1:0]       sync_q;
  logic             pressed;
  btn_state_e       state_q, state_d;
  logic [DbW-1:0]   db_q, db_d, db_inc;
  logic [HoldW-1:0] hold_q, hold_d, hold_inc;
  logic [RepW-1:0]  rep_q, rep_d, rep_inc;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  // Idle level of the synchroniser is "not pressed" so reset never fakes a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{~ActiveLevel}};
    end else begin
      sync_q <= {sync_q[0], pin_i};
    end
  end

  assign pressed  = (sync_q[1] == ActiveLevel);
  assign db_inc   = db_q + 1'b1;
  assign hold_inc = hold_q + 1'b1;
  assign rep_inc  = rep_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    db_d      = db_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pressed) begin
          state_d = StDbPress;
          db_d    = '0;
        end
      end
      StDbPress: begin
        if (!pressed) begin
          state_d = StIdle;
        end else if (tick_i) begin
          if (db_inc == DbMax) begin
            state_d = StHeld;
            press_d = 1'b1;
            level_d = 1'b1;
            hold_d  = '0;
            rep_d   = '0;
          end else begin
            db_d = db_inc;
          end
        end
      end
      StHeld: begin
        if (!pressed) begin
          state_d = StDbRelease;
          db_d    = '0;
        end else if (tick_i) begin
          if (hold_q != HoldMax) begin
            hold_d = hold_inc;
            long_d = (hold_inc == HoldMax);
          end else if (RepEnable) begin
            // Repeat counting starts on the tick after the long pulse, so the
            // two can never share a cycle.
            if (rep_inc == RepMax) begin
              rep_d    = '0;
              repeat_d = repeat_en_i;
            end else begin
              rep_d = rep_inc;
            end
          end
        end
      end
      StDbRelease: begin
        // Bounce back keeps hold/rep counts: a glitch must not restart the long timer.
        if (pressed) begin
          state_d = StHeld;
        end else if (tick_i) begin
          if (db_inc == DbMax) begin
            state_d   = StIdle;
            release_d = 1'b1;
            level_d   = 1'b0;
          end else begin
            db_d = db_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      db_q      <= '0;
      hold_q    <= '0;
      rep_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_q      <= db_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_multi_debounce.sv
// N-channel button debouncer with press/release/long/auto-repeat pulses.
// A single prescaler produces a millisecond tick shared by all channels.
// Ports:
//   clk, rst (async, active-low)
//   btns_in        : raw button pins
//   repeat_en_in   : per-channel auto-repeat enable
//   btn_level_out  : debounced level, 1 = pressed
//   btn_press_out, btn_release_out, btn_long_out, btn_repeat_out : 1-cycle pulses
module btn_multi_debounce
  import btn_pkg::*;
#(
  parameter int unsigned FREQUENCY_IN = 100_000_000,
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned DEBOUNCE_MS  = 20,
  parameter int unsigned LONG_MS      = 1000,
  parameter int unsigned REPEAT_MS    = 200,
  parameter bit          ACTIVE_LEVEL = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btns_in,
  input  logic [CHANNELS-1:0] repeat_en_in,
  output logic [CHANNELS-1:0] btn_level_out,
  output logic [CHANNELS-1:0] btn_press_out,
  output logic [CHANNELS-1:0] btn_release_out,
  output logic [CHANNELS-1:0] btn_long_out,
  output logic [CHANNELS-1:0] btn_repeat_out
);

  localparam int unsigned TickDiv = tick_div(FREQUENCY_IN);
  localparam int unsigned PreW    = cnt_width(TickDiv - 1);
  localparam logic [PreW-1:0] PreMax = PreW'(TickDiv - 1);

  logic [PreW-1:0] presc_q, presc_d;
  logic            tick;

  assign tick = (presc_q == PreMax);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    btn_channel #(
      .DebounceMs  (DEBOUNCE_MS),
      .LongMs      (LONG_MS),
      .RepeatMs    (REPEAT_MS),
      .ActiveLevel (ACTIVE_LEVEL)
    ) u_ch (
      .clk_i       (clk),
      .rst_ni      (rst),
      .tick_i      (tick),
      .pin_i       (btns_in[i]),
      .repeat_en_i (repeat_en_in[i]),
      .level_o     (btn_level_out[i]),
      .press_o     (btn_press_out[i]),
      .release_o   (btn_release_out[i]),
      .long_o      (btn_long_out[i]),
      .repeat_o    (btn_repeat_out[i])
    );
  end

endmodule

// File: tb/tb_btn_multi_debounce.sv
// Directed bench for btn_multi_debounce: tick every 8 clk, debounce 4 ticks,
// long at 10 ticks, repeat every 3 ticks.
module tb_btn_multi_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btns = 4'h0;
  logic [3:0] ren = 4'h0;
  logic [3:0] level, press, rel, lng, rpt;

  btn_multi_debounce #(
    .FREQUENCY_IN (8000),
    .CHANNELS     (4),
    .DEBOUNCE_MS  (4),
    .LONG_MS      (10),
    .REPEAT_MS    (3),
    .ACTIVE_LEVEL (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btns_in         (btns),
    .repeat_en_in    (ren),
    .btn_level_out   (level),
    .btn_press_out   (press),
    .btn_release_out (rel),
    .btn_long_out    (lng),
    .btn_repeat_out  (rpt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse bookkeeping: kind 0 press, 1 release, 2 long, 3 repeat.
  int       cnt  [4][4];
  int       last [4][4];
  int       base [4][4];
  int       viol = 0;
  bit [3:0] cur  [4];
  bit [3:0] prv  [4];

  always @(negedge clk) begin
    cur[0] = press;
    cur[1] = rel;
    cur[2] = lng;
    cur[3] = rpt;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (cur[k][i]) begin
          cnt[k][i]++;
          last[k][i] = cyc;
          if (prv[k][i]) viol++;
        end
      end
    end
    if ((lng & rpt) != 4'h0) viol++;
    if ((rel & (press | lng | rpt)) != 4'h0) viol++;
    prv = cur;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    base = cnt;
  endtask

  function automatic int delta(input int kind, input int ch);
    return cnt[kind][ch] - base[kind][ch];
  endfunction

  task automatic wait_evt(input int kind, input int ch, input int bound, output int at);
    int start;
    start = cnt[kind][ch];
    at = -1;
    for (int k = 0; k < bound; k++) begin
      step(1);
      if (cnt[kind][ch] != start) begin
        at = last[kind][ch];
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  int c0, tp, tl, tr, t1, t2, t3;

  initial begin
    // Reset with all buttons held.
    rst  = 1'b0;
    btns = 4'hF;
    step(5);
    check("reset_level", level, 4'h0);
    check("reset_press", press, 4'h0);
    check("reset_other", {rel, lng, rpt}, 12'h000);

    rst = 1'b1;
    c0  = cyc;
    snap();
    wait_evt(0, 0, 60, tp);
    check("post_reset_press_latency", (tp - c0 >= 27) && (tp - c0 <= 35), 1);
    for (int i = 0; i < 4; i++) begin
      check("post_reset_press_count", delta(0, i), 1);
      check("post_reset_press_same_cycle", last[0][i], tp);
    end
    step(1);
    check("post_reset_press_width", press, 4'h0);
    check("post_reset_level", level, 4'hF);

    // Release everything before the long timer can fire.
    btns = 4'h0;
    wait_evt(1, 0, 80, tr);
    step(1);
    check("release_all_level", level, 4'h0);
    for (int i = 0; i < 4; i++) begin
      check("release_all_count", delta(1, i), 1);
      check("release_all_no_long", delta(2, i), 0);
    end

    // Ch0 short glitch: rejected.
    snap();
    btns[0] = 1'b1;
    step(20);
    btns[0] = 1'b0;
    step(60);
    check("glitch_no_press", delta(0, 0), 0);
    check("glitch_no_release", delta(1, 0), 0);
    check("glitch_level", level[0], 1'b0);

    // Ch1 bouncy press, hold past long, clean release, no repeat.
    snap();
    for (int k = 0; k < 3; k++) begin
      btns[1] = 1'b1;
      step(5);
      btns[1] = 1'b0;
      step(5);
    end
    btns[1] = 1'b1;
    wait_evt(0, 1, 80, tp);
    wait_evt(2, 1, 100, tl);
    check("ch1_long_delay", tl - tp, 80);
    step(60);
    check("ch1_level_held", level[1], 1'b1);
    btns[1] = 1'b0;
    wait_evt(1, 1, 60, tr);
    check("ch1_press_count", delta(0, 1), 1);
    check("ch1_long_count", delta(2, 1), 1);
    check("ch1_repeat_count", delta(3, 1), 0);
    check("ch1_release_count", delta(1, 1), 1);

    // Ch2 auto-repeat, then disable repeat mid-hold.
    snap();
    ren[2]  = 1'b1;
    btns[2] = 1'b1;
    wait_evt(0, 2, 60, tp);
    wait_evt(2, 2, 100, tl);
    check("ch2_long_delay", tl - tp, 80);
    wait_evt(3, 2, 40, t1);
    check("ch2_repeat1_delay", t1 - tp, 104);
    wait_evt(3, 2, 40, t2);
    check("ch2_repeat2_delay", t2 - tp, 128);
    wait_evt(3, 2, 40, t3);
    check("ch2_repeat3_delay", t3 - tp, 152);
    step(2);
    ren[2] = 1'b0;
    step(100);
    check("ch2_repeat_stopped", delta(3, 2), 3);
    check("ch2_level_still_held", level[2], 1'b1);
    check("ch2_long_once", delta(2, 2), 1);
    btns[2] = 1'b0;
    wait_evt(1, 2, 60, tr);
    check("ch2_release_count", delta(1, 2), 1);

    // Ch3 release glitch after long: counts frozen, no release, no second long.
    snap();
    ren[3]  = 1'b1;
    btns[3] = 1'b1;
    wait_evt(0, 3, 60, tp);
    wait_evt(2, 3, 100, tl);
    step(10);
    btns[3] = 1'b0;
    step(10);
    btns[3] = 1'b1;
    wait_evt(3, 3, 40, t1);
    check("ch3_repeat1_after_glitch", t1 - tp, 112);
    wait_evt(3, 3, 40, t2);
    check("ch3_repeat2_after_glitch", t2 - tp, 136);
    check("ch3_no_release", delta(1, 3), 0);
    check("ch3_long_once", delta(2, 3), 1);
    check("ch3_press_once", delta(0, 3), 1);
    btns[3] = 1'b0;
    ren[3]  = 1'b0;
    wait_evt(1, 3, 60, tr);
    check("ch3_release_count", delta(1, 3), 1);

    // Async reset mid-hold on all channels.
    snap();
    btns = 4'hF;
    wait_evt(0, 0, 60, tp);
    step(50);
    check("hold_before_reset_level", level, 4'hF);
    rst = 1'b0;
    #1;
    check("async_reset_level", level, 4'h0);
    check("async_reset_pulses", {press, rel, lng, rpt}, 16'h0000);
    step(3);
    rst = 1'b1;
    c0  = cyc;
    wait_evt(0, 0, 60, tp);
    check("rearm_press_latency", (tp - c0 >= 27) && (tp - c0 <= 35), 1);
    wait_evt(2, 0, 100, tl);
    check("rearm_long_delay", tl - tp, 80);
    for (int i = 0; i < 4; i++) begin
      check("rearm_press_count", delta(0, i), 2);
      check("rearm_long_count", delta(2, i), 1);
      check("rearm_long_same_cycle", last[2][i], tl);
    end

    check("pulse_invariants", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
